fpu_issue_ctrl: RTL and testbench
=================================

# fpu_issue_ctrl

Requester-side controller for the floating-point unit's start/done handshake. It accepts floating-point operation requests from the core's execute stage over a valid/ready interface. It drives operands, operation code and a one-cycle `fpu_start` pulse into the FPU, then waits for `fpu_done` and captures the result. The result and destination register index go to the FP register-file writeback port. A watchdog converts a hung FPU into an error writeback, so the pipeline never deadlocks.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 64: maximum cycles in WAIT before the watchdog fires. 0 disables the watchdog.
- `CNT_W`, default 16: width of the completed-operation counter.

Ports:
- `clk` in 1: clock. All state updates on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept a request.
- `req_op` in 2: FPU operation code, passed through unchanged.
- `req_a`, `req_b` in 32: IEEE-754 single-precision operands.
- `req_rd` in 5: destination FP register index.
- `fpu_a`, `fpu_b` out 32: operands to the FPU.
- `fpu_op` out 2: operation to the FPU.
- `fpu_start` out 1: start pulse.
- `fpu_done` in 1: FPU completion.
- `fpu_r` in 32: FPU result, valid while `fpu_done` is high.
- `wb_valid` out 1: writeback present.
- `wb_ready` in 1: register file accepts the writeback.
- `wb_rd` out 5: destination index.
- `wb_data` out 32: result.
- `wb_err` out 1: writeback produced by the watchdog.
- `op_count` out CNT_W: completed writebacks, saturating.

## Operation
- FSM states: IDLE, START, WAIT, WB.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`: latch op, a, b and rd into holding registers, clear the watchdog, go to START.
- **START**
  - `fpu_start`=1 for exactly this cycle, then go to WAIT.
  - `fpu_done` seen in START is ignored.
- **WAIT**
  - On `fpu_done`=1: capture `fpu_r` into `wb_data`, set `wb_err`=0, go to WB.
  - Otherwise increment the watchdog. When it reaches `TIMEOUT_CYCLES`: set `wb_data`=32'h7FC00000 (quiet NaN), set `wb_err`=1, go to WB.
  - If `fpu_done` and the timeout coincide, `fpu_done` wins.
- **WB**
  - `wb_valid`=1, with `wb_rd`, `wb_data` and `wb_err` held stable until `wb_ready`.
  - On `wb_ready`: increment `op_count` (saturates at all-ones), go to IDLE.
- `fpu_a`, `fpu_b` and `fpu_op` come from the holding registers. They are stable from START until the exit from WAIT.
- `fpu_done` outside WAIT is ignored. A late `fpu_done` after a timeout is dropped.
- Only one operation is in flight at a time. `req_ready` is 0 in START, WAIT and WB.

## Timing
- Reset values:
  - state=IDLE, `req_ready`=1.
  - `fpu_start`=0, `wb_valid`=0, `wb_err`=0.
  - `fpu_a`, `fpu_b`, `wb_data` = 0; `fpu_op` = 0; `wb_rd` = 0; `op_count` = 0.
  - Watchdog = 0.
- Request accepted at edge E0; `fpu_start` is high in cycle E0+1.
- `fpu_done` sampled high at edge Ed gives `wb_valid` from cycle Ed+1 onward.
  - Minimum accept-to-`wb_valid` latency is 3 cycles (`fpu_done` in the first WAIT cycle).
- Watchdog fires on the edge ending the `TIMEOUT_CYCLES`-th WAIT cycle; `wb_valid` follows the next cycle.
- After a WB handshake at edge Ew, `req_ready`=1 in cycle Ew+1. There is no IDLE bypass.
- Reset mid-operation aborts immediately to IDLE with all outputs at reset values. Nothing is written back.

## Structure
- Shared package `fpu_pkg`:
  - state enum `fpu_issue_state_t` (IDLE, START, WAIT, WB);
  - constant `FPU_QNAN` = 32'h7FC00000;
  - 2-bit op typedef `fpu_op_t`.
- One sub-module, `fpu_timeout_cnt`: a clear/enable counter that raises `expired` at `TIMEOUT_CYCLES` and is tied off when the parameter is 0.

## Test plan
- **Basic add:** request op=00, a=32'h3F800000, b=32'h40000000, rd=5; FPU model raises done 4 cycles after start with r=32'h40400000.
  - Expect one `fpu_start` pulse.
  - Expect `wb_valid` with rd=5, data=32'h40400000, err=0.
  - Expect `op_count`=1.
- **Writeback backpressure:** hold `wb_ready`=0 for 5 cycles.
  - `wb_*` stay stable; `req_ready` stays 0.
  - Accept on the 6th cycle, then `req_ready`=1 the next cycle.
- **Timeout:** `TIMEOUT_CYCLES`=8, FPU never responds.
  - `wb_data`=32'h7FC00000 and `wb_err`=1 after 8 WAIT cycles.
  - A later `fpu_done` pulse is ignored: no second `wb_valid`.
- **Done/timeout tie:** done arrives exactly on the expiry cycle.
  - Expect `wb_err`=0 and data = `fpu_r`.
- **Back-to-back:** 3 consecutive requests with `req_valid` held high.
  - Exactly 3 starts and 3 writebacks, in order, with matching rd.
  - No `fpu_start` while not in START.
- **Reset mid-WAIT:** assert `rst` 2 cycles after start.
  - Outputs return to reset values asynchronously; no `wb_valid`.
  - `op_count`=0; next request proceeds normally.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU issue controller.
//   fpu_issue_state_t : controller FSM states (IDLE, START, WAIT, WB)
//   fpu_op_t          : FPU operation code, passed through unchanged
//   fpu_req_t         : request payload held for the lifetime of one operation
//   FPU_QNAN          : result written back when the watchdog fires
package fpu_pkg;

  localparam int unsigned FPU_OP_W   = 2;
  localparam int unsigned FPU_DATA_W = 32;
  localparam int unsigned FPU_RD_W   = 5;

  localparam logic [FPU_DATA_W-1:0] FPU_QNAN = 32'h7FC0_0000;

  typedef logic [FPU_OP_W-1:0] fpu_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    WB    = 2'd3
  } fpu_issue_state_t;

  typedef struct packed {
    fpu_op_t               op;
    logic [FPU_DATA_W-1:0] a;
    logic [FPU_DATA_W-1:0] b;
    logic [FPU_RD_W-1:0]   rd;
  } fpu_req_t;

  // Builds the held payload from the individual request fields.
  function automatic fpu_req_t make_req(input fpu_op_t op,
                                        input logic [FPU_DATA_W-1:0] a,
                                        input logic [FPU_DATA_W-1:0] b,
                                        input logic [FPU_RD_W-1:0] rd);
    fpu_req_t r;
    r.op = op;
    r.a  = a;
    r.b  = b;
    r.rd = rd;
    return r;
  endfunction

endpackage

// File: rtl/fpu_timeout_cnt.sv
// Watchdog counter for the FPU issue controller.
// Counts enabled cycles since the last clear; expired_c is high during the
// enabled cycle whose closing edge would bring the count to TIMEOUT_CYCLES,
// so the caller can leave its wait state on that very edge.
// TIMEOUT_CYCLES = 0 ties expired_c low (watchdog disabled).
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   clr_i      : restart the count from zero
//   en_i       : count this cycle
//   expired_c  : combinational expiry indication
module fpu_timeout_cnt
  import fpu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_c
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      assign expired_c = 1'b0;
    end else begin : g_on
      localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;

      // Next count: clear has priority; saturate at the limit.
      always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
          cnt_d = '0;
        end else if (en_i && (cnt_q != CW'(TIMEOUT_CYCLES))) begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      // Expire on the enabled cycle that completes the TIMEOUT_CYCLES-th count.
      assign expired_c = en_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    end
  endgenerate

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Requester-side controller for the FPU start/done handshake.
// Accepts one request at a time, pulses fpu_start for one cycle, waits for
// fpu_done (or the watchdog), then offers the result on the writeback port.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   req_valid/req_ready           : request handshake from execute stage
//   req_op, req_a, req_b, req_rd  : request payload
//   fpu_a, fpu_b, fpu_op          : operands/op to the FPU (held stable)
//   fpu_start                     : one-cycle start pulse
//   fpu_done, fpu_r               : FPU completion and result
//   wb_valid/wb_ready             : writeback handshake to FP register file
//   wb_rd, wb_data, wb_err        : writeback payload (wb_err = watchdog)
//   op_count                      : completed writebacks, saturating
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [FPU_OP_W-1:0]   req_op,
  input  logic [FPU_DATA_W-1:0] req_a,
  input  logic [FPU_DATA_W-1:0] req_b,
  input  logic [FPU_RD_W-1:0]   req_rd,
  output logic [FPU_DATA_W-1:0] fpu_a,
  output logic [FPU_DATA_W-1:0] fpu_b,
  output logic [FPU_OP_W-1:0]   fpu_op,
  output logic                  fpu_start,
  input  logic                  fpu_done,
  input  logic [FPU_DATA_W-1:0] fpu_r,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [FPU_RD_W-1:0]   wb_rd,
  output logic [FPU_DATA_W-1:0] wb_data,
  output logic                  wb_err,
  output logic [CNT_W-1:0]      op_count
);

  fpu_issue_state_t      state_q;
  fpu_req_t              hold_q;
  logic                  req_ready_q;
  logic                  fpu_start_q;
  logic                  wb_valid_q;
  logic                  wb_err_q;
  logic [FPU_DATA_W-1:0] wb_data_q;
  logic [CNT_W-1:0]      op_count_q;

  logic accept_c;
  logic wdog_en_c;
  logic wdog_exp_c;

  assign accept_c  = (state_q == IDLE) && req_valid;
  // Watchdog only advances on WAIT cycles that did not complete.
  assign wdog_en_c = (state_q == WAIT) && !fpu_done;

  fpu_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (accept_c),
    .en_i     (wdog_en_c),
    .expired_c(wdog_exp_c)
  );

  // Controller FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      req_ready_q <= 1'b1;
      fpu_start_q <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_err_q    <= 1'b0;
      wb_data_q   <= '0;
      op_count_q  <= '0;
    end else begin
      fpu_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            hold_q      <= make_req(req_op, req_a, req_b, req_rd);
            req_ready_q <= 1'b0;
            fpu_start_q <= 1'b1;
            state_q     <= START;
          end
        end
        START: begin
          // A done pulse here belongs to nothing we issued; ignore it.
          state_q <= WAIT;
        end
        WAIT: begin
          // Done takes priority over a coincident watchdog expiry.
          if (fpu_done) begin
            wb_data_q  <= fpu_r;
            wb_err_q   <= 1'b0;
            wb_valid_q <= 1'b1;
            state_q    <= WB;
          end else if (wdog_exp_c) begin
            wb_data_q  <= FPU_QNAN;
            wb_err_q   <= 1'b1;
            wb_valid_q <= 1'b1;
            state_q    <= WB;
          end
        end
        WB: begin
          if (wb_ready) begin
            wb_valid_q  <= 1'b0;
            req_ready_q <= 1'b1;
            if (op_count_q != '1) begin
              op_count_q <= op_count_q + CNT_W'(1);
            end
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign fpu_a     = hold_q.a;
  assign fpu_b     = hold_q.b;
  assign fpu_op    = hold_q.op;
  assign fpu_start = fpu_start_q;
  assign wb_valid  = wb_valid_q;
  assign wb_rd     = hold_q.rd;
  assign wb_data   = wb_data_q;
  assign wb_err    = wb_err_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Self-checking bench for fpu_issue_ctrl (watchdog set to 8 cycles).
module tb_fpu_issue_ctrl;

  localparam int unsigned TMO  = 8;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam int          NEVER = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [4:0]  req_rd;
  logic [31:0] fpu_a;
  logic [31:0] fpu_b;
  logic [1:0]  fpu_op;
  logic        fpu_start;
  logic        fpu_done;
  logic [31:0] fpu_r;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_err;
  logic [15:0] op_count;

  always #5 clk = ~clk;

  fpu_issue_ctrl #(
    .TIMEOUT_CYCLES(TMO),
    .CNT_W         (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op   (req_op),
    .req_a    (req_a),
    .req_b    (req_b),
    .req_rd   (req_rd),
    .fpu_a    (fpu_a),
    .fpu_b    (fpu_b),
    .fpu_op   (fpu_op),
    .fpu_start(fpu_start),
    .fpu_done (fpu_done),
    .fpu_r    (fpu_r),
    .wb_valid (wb_valid),
    .wb_ready (wb_ready),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .wb_err   (wb_err),
    .op_count (op_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, want, $time);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rv;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        dn;
    logic [31:0] r;
    logic        wr;
    logic        e_ready;
    logic        e_start;
    logic        e_wbv;
    logic [31:0] e_data;
    logic        e_err;
    logic [4:0]  e_rd;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tv[$];

  task automatic tv_add(input logic rv, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic dn,
                        input logic [31:0] r, input logic wr, input logic er,
                        input logic es, input logic ew, input logic [31:0] ed,
                        input logic ee, input logic [4:0] erd, input logic [15:0] ec);
    vec_t v;
    v.rv = rv; v.op = op; v.a = a; v.b = b; v.rd = rd;
    v.dn = dn; v.r = r; v.wr = wr;
    v.e_ready = er; v.e_start = es; v.e_wbv = ew;
    v.e_data = ed; v.e_err = ee; v.e_rd = erd; v.e_cnt = ec;
    tv.push_back(v);
  endtask

  // Non-request entry: only FPU/writeback inputs vary.
  task automatic tv_nop(input logic dn, input logic [31:0] r, input logic wr,
                        input logic er, input logic es, input logic ew,
                        input logic [31:0] ed, input logic ee, input logic [4:0] erd,
                        input logic [15:0] ec);
    tv_add(1'b0, 2'd0, 32'h0, 32'h0, 5'd0, dn, r, wr, er, es, ew, ed, ee, erd, ec);
  endtask

  task automatic build_table();
    // basic add, done 4 cycles after start, then 5 cycles of wb backpressure
    tv_add(1'b1, 2'd0, 32'h3F80_0000, 32'h4000_0000, 5'd5, 1'b0, 32'h0, 1'b0,
           1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 16'd0);
    tv_nop(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 5'd5, 16'd0);
    for (int i = 0; i < 3; i++)
      tv_nop(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 5'd5, 16'd0);
    tv_nop(1'b1, 32'h4040_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 5'd5, 16'd0);
    for (int i = 0; i < 5; i++)
      tv_nop(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h4040_0000, 1'b0, 5'd5, 16'd0);
    tv_nop(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h4040_0000, 1'b0, 5'd5, 16'd0);
    // timeout: FPU silent for 8 WAIT cycles, late done pulses afterwards
    tv_add(1'b1, 2'd2, 32'hC0A0_0000, 32'h3F00_0000, 5'd9, 1'b0, 32'h0, 1'b0,
           1'b1, 1'b0, 1'b0, 32'h4040_0000, 1'b0, 5'd5, 16'd1);
    tv_nop(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h4040_0000, 1'b0, 5'd9, 16'd1);
    for (int i = 0; i < 8; i++)
      tv_nop(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h4040_0000, 1'b0, 5'd9, 16'd1);
    tv_nop(1'b1, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 1'b1, QNAN, 1'b1, 5'd9, 16'd1);
    tv_nop(1'b1, 32'h8765_4321, 1'b0, 1'b1, 1'b0, 1'b0, QNAN, 1'b1, 5'd9, 16'd2);
    // done/timeout tie, with a stray done during START
    tv_add(1'b1, 2'd1, 32'h4100_0000, 32'h4000_0000, 5'd17, 1'b0, 32'h0, 1'b0,
           1'b1, 1'b0, 1'b0, QNAN, 1'b1, 5'd9, 16'd2);
    tv_nop(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 1'b0, QNAN, 1'b1, 5'd17, 16'd2);
    for (int i = 0; i < 7; i++)
      tv_nop(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, QNAN, 1'b1, 5'd17, 16'd2);
    tv_nop(1'b1, 32'h4120_0000, 1'b0, 1'b0, 1'b0, 1'b0, QNAN, 1'b1, 5'd17, 16'd2);
    tv_nop(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h4120_0000, 1'b0, 5'd17, 16'd2);
    tv_nop(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h4120_0000, 1'b0, 5'd17, 16'd3);
  endtask

  // ---------------- transaction-level reference model ----------------
  // Each accepted request gets a chosen FPU delay d; from that the model
  // knows the start cycle, the writeback cycle and the expected result.
  int          n;
  int          start_cyc;
  int          wbv_cyc;
  int          done_cyc;
  bit          inflight;
  bit          pend;
  logic [1:0]  p_op;
  logic [31:0] p_a;
  logic [31:0] p_b;
  logic [4:0]  p_rd;
  logic [1:0]  e_op;
  logic [31:0] e_a;
  logic [31:0] e_b;
  logic [31:0] e_r;
  logic [31:0] e_data;
  logic        e_err;
  logic [4:0]  e_rd;
  int          hs_cnt;
  int          b2b_left;
  logic [4:0]  b2b_rd;
  int          starts_seen;
  int          wb_seen;

  task automatic eng_cycle(input bit b2b);
    int  d;
    int  pick;
    bit  exp_wbv;
    exp_wbv = inflight && (n >= wbv_cyc);
    chk("ref req_ready", 32'(req_ready), 32'(!inflight));
    chk("ref fpu_start", 32'(fpu_start), 32'(inflight && (n == start_cyc)));
    chk("ref wb_valid", 32'(wb_valid), 32'(exp_wbv));
    if (exp_wbv) begin
      chk("ref wb_data", wb_data, e_data);
      chk("ref wb_err", 32'(wb_err), 32'(e_err));
      chk("ref wb_rd", 32'(wb_rd), 32'(e_rd));
    end
    if (inflight && (n < wbv_cyc)) begin
      chk("ref fpu_a", fpu_a, e_a);
      chk("ref fpu_b", fpu_b, e_b);
      chk("ref fpu_op", 32'(fpu_op), 32'(e_op));
    end
    chk("ref op_count", 32'(op_count), 32'(hs_cnt));
    if (fpu_start) starts_seen++;

    // drive this cycle's inputs
    if (!pend && (b2b ? (b2b_left > 0) : ($urandom_range(0, 2) == 0))) begin
      pend = 1'b1;
      p_op = 2'($urandom);
      p_a  = $urandom;
      p_b  = $urandom;
      if (b2b) begin
        p_rd = b2b_rd;
        b2b_rd++;
        b2b_left--;
      end else begin
        p_rd = 5'($urandom);
      end
    end
    req_valid = pend;
    req_op    = p_op;
    req_a     = p_a;
    req_b     = p_b;
    req_rd    = p_rd;
    wb_ready  = b2b ? 1'b1 : ($urandom_range(0, 3) != 0);
    if (inflight && (n >= start_cyc) && (n < wbv_cyc)) begin
      // START/WAIT: only the scheduled response, plus stray pulses in START
      fpu_done = (n == done_cyc) || ((n == start_cyc) && !b2b && ($urandom_range(0, 3) == 0));
      fpu_r    = (n == done_cyc) ? e_r : $urandom;
    end else begin
      // IDLE/WB: scheduled late response or random noise, both must be ignored
      fpu_done = (inflight && (n == done_cyc)) || (!b2b && ($urandom_range(0, 4) == 0));
      fpu_r    = $urandom;
    end
    if (wb_valid && wb_ready) wb_seen++;

    // advance the model
    if (inflight) begin
      if (exp_wbv && wb_ready) begin
        inflight = 1'b0;
        hs_cnt++;
      end
    end else if (pend) begin
      inflight  = 1'b1;
      pend      = 1'b0;
      start_cyc = n + 1;
      pick      = int'($urandom_range(0, 9));
      if (b2b)            d = 1;
      else if (pick <= 6) d = int'($urandom_range(1, TMO));
      else if (pick == 7) d = int'(TMO);
      else if (pick == 8) d = int'(TMO) + 1;
      else                d = NEVER;
      done_cyc = start_cyc + d;
      wbv_cyc  = start_cyc + ((d <= int'(TMO)) ? d : int'(TMO)) + 1;
      e_r      = $urandom;
      e_data   = (d <= int'(TMO)) ? e_r : QNAN;
      e_err    = (d > int'(TMO));
      e_op     = p_op;
      e_a      = p_a;
      e_b      = p_b;
      e_rd     = p_rd;
    end
    n++;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = 2'd0;
    req_a     = 32'h0;
    req_b     = 32'h0;
    req_rd    = 5'd0;
    fpu_done  = 1'b0;
    fpu_r     = 32'h0;
    wb_ready  = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset fpu_a", fpu_a, 32'h0);
    chk("reset fpu_b", fpu_b, 32'h0);
    chk("reset fpu_op", 32'(fpu_op), 32'h0);
    rst = 1'b0;

    build_table();
    foreach (tv[i]) begin
      @(negedge clk);
      chk($sformatf("tv%0d req_ready", i), 32'(req_ready), 32'(tv[i].e_ready));
      chk($sformatf("tv%0d fpu_start", i), 32'(fpu_start), 32'(tv[i].e_start));
      chk($sformatf("tv%0d wb_valid", i), 32'(wb_valid), 32'(tv[i].e_wbv));
      chk($sformatf("tv%0d wb_data", i), wb_data, tv[i].e_data);
      chk($sformatf("tv%0d wb_err", i), 32'(wb_err), 32'(tv[i].e_err));
      chk($sformatf("tv%0d wb_rd", i), 32'(wb_rd), 32'(tv[i].e_rd));
      chk($sformatf("tv%0d op_count", i), 32'(op_count), 32'(tv[i].e_cnt));
      req_valid = tv[i].rv;
      req_op    = tv[i].op;
      req_a     = tv[i].a;
      req_b     = tv[i].b;
      req_rd    = tv[i].rd;
      fpu_done  = tv[i].dn;
      fpu_r     = tv[i].r;
      wb_ready  = tv[i].wr;
    end

    // reset two cycles after start, while waiting on the FPU
    @(negedge clk);
    chk("rstw req_ready", 32'(req_ready), 32'h1);
    req_valid = 1'b1; req_op = 2'd3; req_a = 32'h4049_0FDB; req_b = 32'h402D_F854;
    req_rd = 5'd7; fpu_done = 1'b0; wb_ready = 1'b1;
    @(negedge clk);
    chk("rstw fpu_start", 32'(fpu_start), 32'h1);
    chk("rstw fpu_a", fpu_a, 32'h4049_0FDB);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rstw req_ready", 32'(req_ready), 32'h1);
    chk("rstw fpu_start0", 32'(fpu_start), 32'h0);
    chk("rstw wb_valid", 32'(wb_valid), 32'h0);
    chk("rstw wb_err", 32'(wb_err), 32'h0);
    chk("rstw wb_data", wb_data, 32'h0);
    chk("rstw wb_rd", 32'(wb_rd), 32'h0);
    chk("rstw fpu_a0", fpu_a, 32'h0);
    chk("rstw fpu_b", fpu_b, 32'h0);
    chk("rstw fpu_op", 32'(fpu_op), 32'h0);
    chk("rstw op_count", 32'(op_count), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rstw no wb", 32'(wb_valid), 32'h0);
    end

    // back-to-back: req_valid held high for three requests
    n = 0; inflight = 1'b0; pend = 1'b0; hs_cnt = 0;
    b2b_left = 3; b2b_rd = 5'd1; starts_seen = 0; wb_seen = 0;
    repeat (25) begin
      @(negedge clk);
      eng_cycle(1'b1);
    end
    chk("b2b starts", 32'(starts_seen), 32'd3);
    chk("b2b writebacks", 32'(wb_seen), 32'd3);

    // randomized traffic against the reference model
    repeat (3000) begin
      @(negedge clk);
      eng_cycle(1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
